// File: rtl/video_pkg.sv
// Shared video geometry for the tile scan-out path: map/tile sizes, pixel scaling
// and the fixed render latency, plus the world-coordinate and map-address helpers.
package video_pkg;

    localparam int MAP_COLS_LOG2  = 6;
    localparam int MAP_ROWS_LOG2  = 5;
    localparam int TILE_LOG2      = 3;
    localparam int PIX_SCALE_LOG2 = 1;
    localparam int RENDER_LAT     = 3;

    localparam int WX_W    = MAP_COLS_LOG2 + TILE_LOG2;
    localparam int WY_W    = MAP_ROWS_LOG2 + TILE_LOG2;
    localparam int MAP_AW  = 12;
    localparam int PAT_AW  = 11;
    localparam int CTRL_W  = 3;

    // World coordinates wrap around the virtual map; the carry out is dropped on purpose.
    function automatic logic [WX_W-1:0] world_x(input logic [WX_W-1:0] tile_px,
                                                input logic [WX_W-1:0] scroll);
        return tile_px + scroll;
    endfunction

    function automatic logic [WY_W-1:0] world_y(input logic [WY_W-1:0] tile_px,
                                                input logic [WY_W-1:0] scroll);
        return tile_px + scroll;
    endfunction

    function automatic logic [MAP_AW-1:0] map_addr(input logic [MAP_COLS_LOG2-1:0] col,
                                                   input logic [MAP_ROWS_LOG2-1:0] row);
        return {1'b0, row, col};
    endfunction

endpackage

// File: rtl/tile_renderer_sync_delay.sv
// sync_delay: fixed-depth shift register with synchronous active-low reset, used to
// keep active/hsync/vsync aligned with the pixel pipeline.
module sync_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: turns timing-generator coordinates into map and pattern reads and
// emits one 1-bpp pixel per clock, three clocks after the coordinate is presented.
// Optional scrolling is enabled by defining TILE_RENDERER_SCROLL_EN.
module tile_renderer
    import video_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [9:0]        vid_x,
    input  logic [9:0]        vid_y,
    input  logic              vid_active,
    input  logic              vid_hsync,
    input  logic              vid_vsync,
    input  logic              frame_start,
    input  logic [8:0]        scroll_x_in,
    input  logic [7:0]        scroll_y_in,
    output logic              map_ren,
    output logic [11:0]       map_raddr,
    input  logic [7:0]        map_rdata,
    output logic              pat_ren,
    output logic [10:0]       pat_raddr,
    input  logic [7:0]        pat_rdata,
    output logic              pix_on,
    output logic              pix_active,
    output logic              pix_hsync,
    output logic              pix_vsync
);

    logic [WX_W-1:0]      scroll_x_d;
    logic [WY_W-1:0]      scroll_y_d;
    logic [WX_W-1:0]      wx;
    logic [WY_W-1:0]      wy;

    logic [TILE_LOG2-1:0] fx_p0_q;
    logic [TILE_LOG2-1:0] fy_p0_q;
    logic                 vld_p0_q;
    logic [TILE_LOG2-1:0] fx_p1_q;
    logic                 vld_p1_q;
    logic                 pix_on_d;
    logic                 pix_on_q;
    logic [TILE_LOG2-1:0] bit_sel;

`ifdef TILE_RENDERER_SCROLL_EN
    logic [WX_W-1:0] scroll_x_q;
    logic [WY_W-1:0] scroll_y_q;

    // The pixel on the frame_start cycle already uses the newly requested offset.
    assign scroll_x_d = frame_start ? scroll_x_in : scroll_x_q;
    assign scroll_y_d = frame_start ? scroll_y_in : scroll_y_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scroll_x_q <= '0;
            scroll_y_q <= '0;
        end else begin
            scroll_x_q <= scroll_x_d;
            scroll_y_q <= scroll_y_d;
        end
    end
`else
    logic unused_scroll;

    assign scroll_x_d    = '0;
    assign scroll_y_d    = '0;
    assign unused_scroll = ^{frame_start, scroll_x_in, scroll_y_in};
`endif

    // Stage 0: screen pixel -> world coordinate -> map read, issued combinationally.
    logic unused_coord;

    assign unused_coord = ^{vid_x[0], vid_y[0], vid_y[9]};
    assign wx        = world_x(vid_x[WX_W:PIX_SCALE_LOG2], scroll_x_d);
    assign wy        = world_y(vid_y[WY_W:PIX_SCALE_LOG2], scroll_y_d);
    assign map_ren   = vid_active;
    assign map_raddr = map_addr(wx[WX_W-1:TILE_LOG2], wy[WY_W-1:TILE_LOG2]);

    always_ff @(posedge clk) begin
        fx_p0_q <= wx[TILE_LOG2-1:0];
        fy_p0_q <= wy[TILE_LOG2-1:0];
        fx_p1_q <= fx_p0_q;
    end

    // Stage 1: tile index returned by the map selects the pattern row.
    assign pat_ren   = vld_p0_q & resetn;
    assign pat_raddr = {map_rdata, fy_p0_q};

    // Stage 2: pick the pixel bit; bit 7 of a pattern row is the leftmost pixel.
    assign bit_sel  = ~fx_p1_q;
    assign pix_on_d = vld_p1_q & pat_rdata[bit_sel];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            pix_on_q <= 1'b0;
        end else begin
            vld_p0_q <= vid_active;
            vld_p1_q <= vld_p0_q;
            pix_on_q <= pix_on_d;
        end
    end

    assign pix_on = pix_on_q;

    sync_delay #(
        .DEPTH (RENDER_LAT),
        .WIDTH (CTRL_W)
    ) u_ctrl_delay (
        .clk    (clk),
        .resetn (resetn),
        .d_i    ({vid_active, vid_hsync, vid_vsync}),
        .q_o    ({pix_active, pix_hsync, pix_vsync})
    );

endmodule

// File: tb/tb_tile_renderer.sv
// Randomized bench for tile_renderer with memory models and a coordinate-level
// reference model; works with or without TILE_RENDERER_SCROLL_EN.
module tb_tile_renderer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [9:0]  vid_x = '0;
    logic [9:0]  vid_y = '0;
    logic        vid_active = 1'b0;
    logic        vid_hsync = 1'b0;
    logic        vid_vsync = 1'b0;
    logic        frame_start = 1'b0;
    logic [8:0]  scroll_x_in = '0;
    logic [7:0]  scroll_y_in = '0;
    logic        map_ren;
    logic [11:0] map_raddr;
    logic [7:0]  map_rdata = '0;
    logic        pat_ren;
    logic [10:0] pat_raddr;
    logic [7:0]  pat_rdata = '0;
    logic        pix_on;
    logic        pix_active;
    logic        pix_hsync;
    logic        pix_vsync;

    always #5 clk = ~clk;

    tile_renderer dut (
        .clk         (clk),
        .resetn      (resetn),
        .vid_x       (vid_x),
        .vid_y       (vid_y),
        .vid_active  (vid_active),
        .vid_hsync   (vid_hsync),
        .vid_vsync   (vid_vsync),
        .frame_start (frame_start),
        .scroll_x_in (scroll_x_in),
        .scroll_y_in (scroll_y_in),
        .map_ren     (map_ren),
        .map_raddr   (map_raddr),
        .map_rdata   (map_rdata),
        .pat_ren     (pat_ren),
        .pat_raddr   (pat_raddr),
        .pat_rdata   (pat_rdata),
        .pix_on      (pix_on),
        .pix_active  (pix_active),
        .pix_hsync   (pix_hsync),
        .pix_vsync   (pix_vsync)
    );

    logic [7:0] map_mem [0:4095];
    logic [7:0] pat_mem [0:2047];
    bit         stale_ff = 1'b0;

    // One-clock synchronous-read memories; without a read the data goes stale/garbage.
    always @(posedge clk) begin
        if (map_ren) map_rdata <= map_mem[map_raddr];
        else         map_rdata <= stale_ff ? 8'hFF : 8'($urandom);
        if (pat_ren) pat_rdata <= pat_mem[pat_raddr];
        else         pat_rdata <= stale_ff ? 8'hFF : 8'($urandom);
    end

    int checks = 0;
    int errors = 0;
    int n = 0;

    bit rst_h [4096];
    bit e_act [4096];
    bit e_hs  [4096];
    bit e_vs  [4096];
    bit e_on  [4096];
    int e_maddr [4096];
    int e_paddr [4096];
    int sx_m = 0;
    int sy_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    function automatic bit rh(input int c);
        return (c >= 0) ? rst_h[c] : 1'b0;
    endfunction

    task automatic step(input bit rn, input bit act, input int x, input int y,
                        input bit hs, input bit vs, input bit fs, input int sxi, input int syi);
        int sxe, sye, wx, wy, c, p;
        bit exp_pren;
        @(negedge clk);
        resetn      = rn;
        vid_active  = act;
        vid_x       = 10'(x);
        vid_y       = 10'(y);
        vid_hsync   = hs;
        vid_vsync   = vs;
        frame_start = fs;
        scroll_x_in = 9'(sxi);
        scroll_y_in = 8'(syi);
`ifdef TILE_RENDERER_SCROLL_EN
        sxe = fs ? sxi : sx_m;
        sye = fs ? syi : sy_m;
`else
        sxe = 0;
        sye = 0;
`endif
        wx = (x / 2 + sxe) % 512;
        wy = (y / 2 + sye) % 256;
        rst_h[n]   = rn;
        e_act[n]   = act;
        e_hs[n]    = hs;
        e_vs[n]    = vs;
        e_maddr[n] = (wy / 8) * 64 + wx / 8;
        e_paddr[n] = int'(map_mem[e_maddr[n]]) * 8 + wy % 8;
        e_on[n]    = act && pat_mem[e_paddr[n]][7 - wx % 8];
        #1;
        check("map_ren", 32'(map_ren), 32'(act));
        if (act) check("map_raddr", 32'(map_raddr), e_maddr[n]);
        p = n - 1;
        exp_pren = (p >= 0) && e_act[p] && rst_h[p] && rn;
        check("pat_ren", 32'(pat_ren), 32'(exp_pren));
        if (exp_pren) check("pat_raddr", 32'(pat_raddr), e_paddr[p]);
        c = n - 3;
        if (c >= 0 && rh(c) && rh(c + 1) && rh(c + 2)) begin
            check("pix_on", 32'(pix_on), 32'(e_on[c]));
            check("pix_active", 32'(pix_active), 32'(e_act[c]));
            check("pix_hsync", 32'(pix_hsync), 32'(e_hs[c]));
            check("pix_vsync", 32'(pix_vsync), 32'(e_vs[c]));
        end else begin
            check("pix_on_rst", 32'(pix_on), 32'd0);
            check("pix_active_rst", 32'(pix_active), 32'd0);
            check("pix_hsync_rst", 32'(pix_hsync), 32'd0);
            check("pix_vsync_rst", 32'(pix_vsync), 32'd0);
        end
        if (!rn) begin
            sx_m = 0;
            sy_m = 0;
        end else if (fs) begin
            sx_m = sxi;
            sy_m = syi;
        end
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [3:0] pat_seen;

    initial begin
        for (int i = 0; i < 4096; i++) map_mem[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) pat_mem[i] = 8'($urandom);
        map_mem[0]  = 8'd5;
        pat_mem[40] = 8'h80;

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 1, 0, 0, 0);

        // First tile row: two lit tile pixels followed by two dark ones.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("map_raddr_0", 32'(map_raddr), 32'h000);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        check("pat_raddr_40", 32'(pat_raddr), 32'd40);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        pat_seen[3] = pix_on;
        for (int i = 2; i >= 0; i--) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0);
            pat_seen[i] = pix_on;
        end
        check("pix_pattern", 32'(pat_seen), 32'b1100);

        step(1, 1, 16, 18, 0, 0, 0, 0, 0);
        check("map_raddr_041", 32'(map_raddr), 32'h041);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pat_raddr_041", 32'(pat_raddr), 32'({map_mem[12'h041], 3'd1}));
        idle(3);

        // Inactive pixels with all-ones stale read data must stay dark.
        stale_ff = 1'b1;
        idle(4);
        check("inactive_pix_on", 32'(pix_on), 32'd0);
        check("inactive_pix_active", 32'(pix_active), 32'd0);
        stale_ff = 1'b0;

`ifdef TILE_RENDERER_SCROLL_EN
        step(1, 1, 2, 0, 0, 0, 1, 511, 0);
        check("scroll_wrap_col0", 32'(map_raddr), 32'h000);
        step(1, 1, 0, 0, 0, 0, 0, 511, 0);
        check("scroll_wrap_col63", 32'(map_raddr), 32'h03F);
        step(1, 1, 0, 0, 0, 0, 0, 511, 8);
        check("scroll_y_ignored", 32'(map_raddr), 32'h03F);
        step(1, 1, 0, 0, 0, 0, 0, 511, 8);
        check("scroll_y_still_ignored", 32'(map_raddr), 32'h03F);
        step(1, 1, 0, 0, 0, 0, 1, 511, 8);
        check("scroll_y_row1", 32'(map_raddr), 32'h07F);
        idle(3);
`endif

        // One-cycle reset in the middle of an active line.
        for (int i = 0; i < 4; i++) step(1, 1, 100 + i, 40, 1, 0, 0, 0, 0);
        step(0, 1, 104, 40, 1, 0, 0, 0, 0);
        step(1, 1, 105, 40, 1, 0, 0, 0, 0);
        check("rst_flush_active", 32'(pix_active), 32'd0);
        check("rst_flush_hsync", 32'(pix_hsync), 32'd0);
        step(1, 1, 106, 40, 1, 0, 0, 0, 0);
        step(1, 1, 107, 40, 1, 0, 0, 0, 0);
        check("rst_still_dark", 32'(pix_active), 32'd0);
        step(1, 1, 108, 40, 1, 0, 0, 0, 0);
        check("rst_resume_active", 32'(pix_active), 32'd1);

        // Raster sweep across one line.
        for (int i = 0; i < 300; i++) step(1, 1, i, 77, (i > 280), 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
